// File: rtl/xdom_pulse_receiver.sv
// Destination-domain receiver of a four-phase request/acknowledge pulse link.
// Synchronizes the request, emits one gated pulse per request, counts deliveries, flags drop-outs.
module xdom_pulse_receiver #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 xdom_clk_i,
    input  logic                 grst_i,
    input  logic                 xdom_req_i,
    input  logic                 xdom_ready_i,
    output logic                 xdom_ack_o,
    output logic                 xdom_pulse_o,
    output logic                 busy_o,
    output logic [CNT_WIDTH-1:0] pulse_cnt_o,
    output logic                 err_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        ACK  = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   req_s;
    state_t                 state_q;
    state_t                 state_d;
    logic                   deliver;
    logic                   proto_err;

    // The request is only ever observed through this shift chain.
    always_ff @(posedge xdom_clk_i or posedge grst_i) begin
        if (grst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], xdom_req_i};
        end
    end

    assign req_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge xdom_clk_i or posedge grst_i) begin
        if (grst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        deliver   = 1'b0;
        proto_err = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_s) begin
                    state_d = PEND;
                end
            end
            PEND: begin
                // A sender withdrawing before delivery wins over downstream readiness.
                if (!req_s) begin
                    state_d   = IDLE;
                    proto_err = 1'b1;
                end else if (xdom_ready_i) begin
                    state_d = ACK;
                    deliver = 1'b1;
                end
            end
            ACK: begin
                if (!req_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next-state decode so they align with the FSM edge.
    always_ff @(posedge xdom_clk_i or posedge grst_i) begin
        if (grst_i) begin
            xdom_ack_o   <= 1'b0;
            xdom_pulse_o <= 1'b0;
            busy_o       <= 1'b0;
            pulse_cnt_o  <= '0;
            err_o        <= 1'b0;
        end else begin
            xdom_ack_o   <= (state_d == ACK);
            xdom_pulse_o <= deliver;
            busy_o       <= (state_d != IDLE);
            if (deliver) begin
                pulse_cnt_o <= pulse_cnt_o + CNT_WIDTH'(1);
            end
            if (proto_err) begin
                err_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_xdom_pulse_receiver.sv
// Directed plus randomized handshake bench for xdom_pulse_receiver.
// Expected outputs come from the latency rules and a modulo-16 delivery count.
module tb_xdom_pulse_receiver;

    localparam int S  = 2;
    localparam int CW = 4;

    logic          clk;
    logic          clk_en;
    logic          grst;
    logic          req;
    logic          ready;
    logic          ack;
    logic          pulse;
    logic          busy;
    logic [CW-1:0] cnt;
    logic          err;

    int n_assert;
    int n_fail;
    int exp_cnt;
    int exp_err;

    xdom_pulse_receiver #(
        .SYNC_STAGES(S),
        .CNT_WIDTH  (CW)
    ) dut (
        .xdom_clk_i  (clk),
        .grst_i      (grst),
        .xdom_req_i  (req),
        .xdom_ready_i(ready),
        .xdom_ack_o  (ack),
        .xdom_pulse_o(pulse),
        .busy_o      (busy),
        .pulse_cnt_o (cnt),
        .err_o       (err)
    );

    initial clk = 1'b0;
    always #5 if (clk_en) clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic chk_all(input string tag, input logic e_ack, input logic e_pulse, input logic e_busy);
        chk({tag, ".ack"}, {31'd0, ack}, {31'd0, e_ack});
        chk({tag, ".pulse"}, {31'd0, pulse}, {31'd0, e_pulse});
        chk({tag, ".busy"}, {31'd0, busy}, {31'd0, e_busy});
        chk({tag, ".cnt"}, {28'd0, cnt}, exp_cnt);
        chk({tag, ".err"}, {31'd0, err}, exp_err);
    endtask

    // Sender drops the request; ack must persist for S edges, then everything idles.
    task automatic release_req(input string tag);
        req = 1'b0;
        for (int k = 0; k < S; k++) begin
            step();
            chk_all({tag, ".rel"}, 1'b1, 1'b0, 1'b1);
        end
        step();
        chk_all({tag, ".idle"}, 1'b0, 1'b0, 1'b0);
    endtask

    // Legal handshake: ready withheld for d edges beyond PEND entry, ack held h cycles.
    task automatic handshake(input string tag, input int d, input int h, input logic early);
        ready = early;
        req   = 1'b1;
        if (!early) begin
            for (int k = 0; k <= S + d; k++) begin
                step();
                chk_all({tag, ".wait"}, 1'b0, 1'b0, k >= S);
            end
        end else begin
            for (int k = 0; k <= S; k++) begin
                step();
                chk_all({tag, ".wait"}, 1'b0, 1'b0, k >= S);
            end
        end
        ready = 1'b1;
        step();
        exp_cnt = (exp_cnt + 1) % (1 << CW);
        chk_all({tag, ".pulse"}, 1'b1, 1'b1, 1'b1);
        for (int k = 0; k < h; k++) begin
            ready = 1'($urandom);
            step();
            chk_all({tag, ".hold"}, 1'b1, 1'b0, 1'b1);
        end
        release_req(tag);
    endtask

    // Request withdrawn while waiting in PEND for p extra edges.
    task automatic drop_out(input string tag, input int p);
        ready = 1'b0;
        req   = 1'b1;
        for (int k = 0; k <= S + p; k++) begin
            step();
            chk_all({tag, ".wait"}, 1'b0, 1'b0, k >= S);
        end
        req = 1'b0;
        for (int k = 0; k < S; k++) begin
            step();
            chk_all({tag, ".drop"}, 1'b0, 1'b0, 1'b1);
        end
        step();
        exp_err = 1;
        chk_all({tag, ".err"}, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        exp_cnt  = 0;
        exp_err  = 0;
        clk_en   = 1'b0;
        grst     = 1'b0;
        req      = 1'b0;
        ready    = 1'b0;

        // Asynchronous reset with the clock stopped.
        #3 grst = 1'b1;
        #1;
        chk_all("rst_async", 1'b0, 1'b0, 1'b0);
        clk_en = 1'b1;
        step();
        step();
        grst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            chk_all("rst_hold", 1'b0, 1'b0, 1'b0);
        end

        handshake("single", 0, 2, 1'b1);
        handshake("backpressure", 20 - S, 3, 1'b0);
        handshake("held", 0, 200, 1'b1);

        drop_out("proto", 5 - S);
        handshake("after_err", 1, 2, 1'b0);

        for (int i = 0; i < 20; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                drop_out("rnd_err", int'($urandom_range(0, 4)));
            end else begin
                handshake("rnd_hs", int'($urandom_range(0, 5)), int'($urandom_range(0, 6)),
                          1'($urandom));
            end
        end

        // Reset while in ACK, request still high afterwards is a fresh request.
        ready = 1'b1;
        req   = 1'b1;
        for (int k = 0; k <= S; k++) begin
            step();
            chk_all("rst_ack.wait", 1'b0, 1'b0, k >= S);
        end
        step();
        exp_cnt = (exp_cnt + 1) % (1 << CW);
        chk_all("rst_ack.pulse", 1'b1, 1'b1, 1'b1);
        step();
        chk_all("rst_ack.in_ack", 1'b1, 1'b0, 1'b1);
        #2 grst = 1'b1;
        #1;
        exp_cnt = 0;
        exp_err = 0;
        chk_all("rst_ack.cleared", 1'b0, 1'b0, 1'b0);
        step();
        grst = 1'b0;
        for (int k = 0; k <= S; k++) begin
            step();
            chk_all("rst_rereq.wait", 1'b0, 1'b0, k >= S);
        end
        step();
        exp_cnt = 1;
        chk_all("rst_rereq.pulse", 1'b1, 1'b1, 1'b1);
        release_req("rst_rereq");

        // Counter wrap from a clean reset.
        #2 grst = 1'b1;
        #1;
        exp_cnt = 0;
        chk_all("wrap.rst", 1'b0, 1'b0, 1'b0);
        step();
        grst = 1'b0;
        for (int i = 0; i < 17; i++) begin
            handshake("wrap", int'($urandom_range(0, 2)), 0, 1'($urandom));
        end
        chk("wrap.final_cnt", {28'd0, cnt}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
